// File: rtl/mem_arbiter.sv
// mem_arbiter: three-client DRAM front-end arbiter.
//   Pixel feeder (PF, reads) has fixed top priority. GP instruction fetch
//   (reads) and the line engine (LE, 2-beat writes) share a 1-bit
//   round-robin pointer. Read ownership is recorded in a tag FIFO so that
//   returning 2-beat read bursts can be steered back to PF or GP.
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   pf_req_*                PF read request  (valid/addr in, ready out)
//   gp_req_*                GP read request  (valid/addr in, ready out)
//   le_req_*, le_wdata_*    LE write request + beat 0, then beat 1 handshake
//   af_*                    DRAM address FIFO push port
//   wdf_*                   DRAM write-data FIFO push port
//   rdf_*                   DRAM read-data FIFO pop port (always popping)
//   rd_data_o, *_rd_valid_o read beats routed to their owner
//   err_orphan_o            sticky: read data seen with no outstanding tag
module mem_arbiter #(
  parameter int TAG_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         pf_req_valid_i,
  input  logic [30:0]  pf_req_addr_i,
  output logic         pf_req_ready_o,
  input  logic         gp_req_valid_i,
  input  logic [30:0]  gp_req_addr_i,
  output logic         gp_req_ready_o,
  input  logic         le_req_valid_i,
  input  logic [30:0]  le_req_addr_i,
  input  logic [127:0] le_wdata_i,
  input  logic [15:0]  le_wmask_i,
  output logic         le_req_ready_o,
  input  logic         le_wdata_valid_i,
  output logic         le_wdata_ready_o,
  output logic         af_wr_en_o,
  output logic [30:0]  af_addr_din_o,
  output logic         af_rnw_o,
  input  logic         af_full_i,
  output logic         wdf_wr_en_o,
  output logic [127:0] wdf_din_o,
  output logic [15:0]  wdf_mask_din_o,
  input  logic         wdf_full_i,
  input  logic         rdf_valid_i,
  input  logic [127:0] rdf_dout_i,
  output logic         rdf_rd_en_o,
  output logic [127:0] rd_data_o,
  output logic         pf_rd_valid_o,
  output logic         gp_rd_valid_o,
  output logic         err_orphan_o
);

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  typedef enum logic {IDLE = 1'b0, WR_B1 = 1'b1} state_e;

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;       // 0 prefers GP, 1 prefers LE
  logic [TAG_DEPTH-1:0]  tags_q;           // 0 = PF, 1 = GP
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         cnt_q;
  logic                  beat_q;           // 0 = first beat of a burst
  logic                  err_q;

  logic tag_empty, tag_full, head_tag;
  logic push, pop, tag_in;
  logic can_rd, can_wr, gnt_pf, gnt_gp, gnt_le, gp_elig, le_elig;

  assign tag_empty    = (cnt_q == '0);
  // Fullness is judged on the registered count, so a same-cycle pop
  // never frees a slot for a same-cycle grant.
  assign tag_full     = (cnt_q >= CW'(TAG_DEPTH));
  assign head_tag     = tags_q[rptr_q];
  assign rdf_rd_en_o  = 1'b1;
  assign err_orphan_o = err_q;
  assign rd_data_o    = rdf_dout_i;

  always_comb begin
    state_d          = state_q;
    rr_d             = rr_q;
    push             = 1'b0;
    pop              = 1'b0;
    tag_in           = 1'b0;
    gnt_pf           = 1'b0;
    gnt_gp           = 1'b0;
    gnt_le           = 1'b0;
    can_rd           = 1'b0;
    can_wr           = 1'b0;
    gp_elig          = 1'b0;
    le_elig          = 1'b0;
    pf_req_ready_o   = 1'b0;
    gp_req_ready_o   = 1'b0;
    le_req_ready_o   = 1'b0;
    le_wdata_ready_o = 1'b0;
    af_wr_en_o       = 1'b0;
    af_rnw_o         = 1'b1;
    af_addr_din_o    = '0;
    wdf_wr_en_o      = 1'b0;
    // Both write beats share the LE data bus; only the enable differs.
    wdf_din_o        = le_wdata_i;
    wdf_mask_din_o   = le_wmask_i;
    pf_rd_valid_o    = 1'b0;
    gp_rd_valid_o    = 1'b0;

    if (rst_n_i) begin
      case (state_q)
        IDLE: begin
          can_rd  = !af_full_i && !tag_full;
          can_wr  = !af_full_i && !wdf_full_i;
          gnt_pf  = pf_req_valid_i && can_rd;
          gp_elig = gp_req_valid_i && can_rd;
          le_elig = le_req_valid_i && can_wr;
          if (!gnt_pf) begin
            if (gp_elig && le_elig) begin
              gnt_gp = !rr_q;
              gnt_le = rr_q;
            end else begin
              gnt_gp = gp_elig;
              gnt_le = le_elig;
            end
          end

          if (gnt_pf || gnt_gp) begin
            af_wr_en_o     = 1'b1;
            af_rnw_o       = 1'b1;
            af_addr_din_o  = gnt_pf ? pf_req_addr_i : gp_req_addr_i;
            pf_req_ready_o = gnt_pf;
            gp_req_ready_o = gnt_gp;
            push           = 1'b1;
            tag_in         = gnt_gp;
          end else if (gnt_le) begin
            af_wr_en_o     = 1'b1;
            af_rnw_o       = 1'b0;
            af_addr_din_o  = le_req_addr_i;
            wdf_wr_en_o    = 1'b1;
            le_req_ready_o = 1'b1;
            state_d        = WR_B1;
          end

          // Pointer points at the side that lost, PF grants leave it alone.
          if (gnt_gp) rr_d = 1'b1;
          if (gnt_le) rr_d = 1'b0;
        end
        WR_B1: begin
          if (le_wdata_valid_i && !wdf_full_i) begin
            le_wdata_ready_o = 1'b1;
            wdf_wr_en_o      = 1'b1;
            state_d          = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // Read return steering; orphan beats are only flagged.
      if (rdf_valid_i && !tag_empty) begin
        pf_rd_valid_o = !head_tag;
        gp_rd_valid_o = head_tag;
        pop           = beat_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      tags_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      beat_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (push) begin
        tags_q[wptr_q] <= tag_in;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (rdf_valid_i) begin
        if (tag_empty) err_q  <= 1'b1;
        else           beat_q <= ~beat_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change just after the falling
// edge and outputs are sampled 1ns later; expected read owners are queued
// when a read grant is expected and popped as the return beats arrive.
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         pf_v, gp_v, le_v, le_wv;
  logic [30:0]  pf_a, gp_a, le_a;
  logic [127:0] le_wd;
  logic [15:0]  le_wm;
  logic         pf_rdy, gp_rdy, le_rdy, le_wrdy;
  logic         af_we, af_rnw, af_full;
  logic [30:0]  af_addr;
  logic         wdf_we, wdf_full;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask;
  logic         rdf_v, rdf_en;
  logic [127:0] rdf_d, rd_data;
  logic         pf_rv, gp_rv, err;

  int   total = 0;
  int   bad   = 0;
  logic sb[$];          // expected owner of each outstanding read (1=GP)
  logic mbeat = 1'b0;   // model beat counter

  mem_arbiter #(.TAG_DEPTH(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .pf_req_valid_i(pf_v), .pf_req_addr_i(pf_a), .pf_req_ready_o(pf_rdy),
    .gp_req_valid_i(gp_v), .gp_req_addr_i(gp_a), .gp_req_ready_o(gp_rdy),
    .le_req_valid_i(le_v), .le_req_addr_i(le_a), .le_wdata_i(le_wd),
    .le_wmask_i(le_wm), .le_req_ready_o(le_rdy),
    .le_wdata_valid_i(le_wv), .le_wdata_ready_o(le_wrdy),
    .af_wr_en_o(af_we), .af_addr_din_o(af_addr), .af_rnw_o(af_rnw),
    .af_full_i(af_full),
    .wdf_wr_en_o(wdf_we), .wdf_din_o(wdf_din), .wdf_mask_din_o(wdf_mask),
    .wdf_full_i(wdf_full),
    .rdf_valid_i(rdf_v), .rdf_dout_i(rdf_d), .rdf_rd_en_o(rdf_en),
    .rd_data_o(rd_data), .pf_rd_valid_o(pf_rv), .gp_rd_valid_o(gp_rv),
    .err_orphan_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a cycle: all requests/returns idle unless the step sets them.
  task automatic step();
    @(negedge clk);
    pf_v = 0; gp_v = 0; le_v = 0; le_wv = 0; rdf_v = 0;
    af_full = 0; wdf_full = 0;
  endtask

  // Grant check: which ready is up and what the address FIFO sees.
  task automatic gchk(input string t, input logic epf, input logic egp,
                      input logic ele, input logic eaf,
                      input logic [30:0] ea, input logic erw);
    chk({t, ".pf_rdy"}, pf_rdy, epf);
    chk({t, ".gp_rdy"}, gp_rdy, egp);
    chk({t, ".le_rdy"}, le_rdy, ele);
    chk({t, ".af_we"},  af_we,  eaf);
    if (eaf) begin
      chk({t, ".af_addr"}, af_addr, ea);
      chk({t, ".af_rnw"},  af_rnw,  erw);
    end
  endtask

  // Check a return beat currently on rdf against the scoreboard.
  task automatic rchk(input string t, input logic [127:0] d);
    logic own;
    if (sb.size() > 0) begin
      own = sb[0];
      chk({t, ".pf_rv"}, pf_rv, !own);
      chk({t, ".gp_rv"}, gp_rv, own);
      chk({t, ".rd_data"}, rd_data, d);
      if (mbeat) void'(sb.pop_front());
      mbeat = ~mbeat;
    end else begin
      chk({t, ".orph_pf_rv"}, pf_rv, 1'b0);
      chk({t, ".orph_gp_rv"}, gp_rv, 1'b0);
    end
  endtask

  task automatic rbeat(input string t, input logic [127:0] d);
    step();
    rdf_v = 1; rdf_d = d;
    #1 rchk(t, d);
  endtask

  task automatic do_reset();
    step();
    rst_n = 0; pf_v = 1; gp_v = 1; le_v = 1; le_wv = 1; rdf_v = 1;
    #1;
    chk("rst.pf_rdy", pf_rdy, 1'b0);
    chk("rst.gp_rdy", gp_rdy, 1'b0);
    chk("rst.le_rdy", le_rdy, 1'b0);
    chk("rst.le_wrdy", le_wrdy, 1'b0);
    chk("rst.af_we", af_we, 1'b0);
    chk("rst.wdf_we", wdf_we, 1'b0);
    chk("rst.rv", {pf_rv, gp_rv}, 2'b00);
    chk("rst.rdf_en", rdf_en, 1'b1);
    sb.delete();
    mbeat = 1'b0;
    step();
    rst_n = 1;
    #1 chk("rst.err", err, 1'b0);
  endtask

  initial begin
    rst_n = 0; pf_v = 0; gp_v = 0; le_v = 0; le_wv = 0; rdf_v = 0;
    af_full = 0; wdf_full = 0; pf_a = '0; gp_a = '0; le_a = '0;
    le_wd = '0; le_wm = '0; rdf_d = '0;
    do_reset();

    // PF beats GP, GP follows next cycle
    step(); pf_v = 1; pf_a = 31'h0000_1111; gp_v = 1; gp_a = 31'h0000_2222;
    #1 gchk("pri.c0", 1, 0, 0, 1, 31'h0000_1111, 1); sb.push_back(0);
    step(); gp_v = 1; gp_a = 31'h0000_2222;
    #1 gchk("pri.c1", 0, 1, 0, 1, 31'h0000_2222, 1); sb.push_back(1);
    for (int i = 0; i < 4; i++) rbeat("pri.ret", 128'hA0 + 128'(i));

    // GP/LE round robin, rr back to 0 after reset
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(); gp_v = 1; le_v = 1; gp_a = 31'(32'h100 + i); le_a = 31'h7ABC_0000;
      #1 gchk("rr.gp", 0, 1, 0, 1, 31'(32'h100 + i), 1); sb.push_back(1);
      step(); gp_v = 1; le_v = 1; le_a = 31'h7ABC_0000;
      le_wd = {4{32'hDEAD_0000 + 32'(i)}}; le_wm = 16'h0F0F;
      #1 gchk("rr.le", 0, 0, 1, 1, 31'h7ABC_0000, 0);
      chk("rr.le.wdf_we", wdf_we, 1'b1);
      chk("rr.le.wdf_din", wdf_din, {4{32'hDEAD_0000 + 32'(i)}});
      chk("rr.le.wdf_mask", wdf_mask, 16'h0F0F);
      step(); gp_v = 1; le_v = 1; le_wv = 1;
      le_wd = {4{32'hBEEF_0000 + 32'(i)}}; le_wm = 16'hF0F0;
      #1 gchk("rr.b1", 0, 0, 0, 0, '0, 0);
      chk("rr.b1.wrdy", le_wrdy, 1'b1);
      chk("rr.b1.wdf_we", wdf_we, 1'b1);
      chk("rr.b1.wdf_din", wdf_din, {4{32'hBEEF_0000 + 32'(i)}});
      chk("rr.b1.wdf_mask", wdf_mask, 16'hF0F0);
    end
    for (int i = 0; i < 4; i++) rbeat("rr.ret", 128'hB0 + 128'(i));

    // Tag FIFO full blocks the fifth read, even on the popping cycle
    for (int i = 0; i < 4; i++) begin
      step(); gp_v = 1; gp_a = 31'(32'h400 + i);
      #1 gchk("full.issue", 0, 1, 0, 1, 31'(32'h400 + i), 1); sb.push_back(1);
    end
    step(); gp_v = 1; gp_a = 31'h0000_0404;
    #1 gchk("full.blk", 0, 0, 0, 0, '0, 0);
    step(); gp_v = 1; rdf_v = 1; rdf_d = 128'hC0;
    #1 rchk("full.r0", 128'hC0); chk("full.r0.gp_rdy", gp_rdy, 1'b0);
    step(); gp_v = 1; rdf_v = 1; rdf_d = 128'hC1;
    #1 rchk("full.r1", 128'hC1); chk("full.r1.gp_rdy", gp_rdy, 1'b0);
    step(); gp_v = 1;
    #1 gchk("full.fifth", 0, 1, 0, 1, 31'h0000_0404, 1); sb.push_back(1);
    for (int i = 0; i < 8; i++) rbeat("full.ret", 128'hD0 + 128'(i));

    // Write beat 1 stalled by wdf_full; reads held off meanwhile
    step(); le_v = 1; le_a = 31'h1234_5678; le_wd = 128'h11; le_wm = 16'hFFFF;
    #1 gchk("wst.le", 0, 0, 1, 1, 31'h1234_5678, 0);
    for (int i = 0; i < 3; i++) begin
      step(); wdf_full = 1; le_wv = 1; pf_v = 1; pf_a = 31'h0000_0055;
      #1 gchk("wst.hold", 0, 0, 0, 0, '0, 0);
      chk("wst.hold.wrdy", le_wrdy, 1'b0);
      chk("wst.hold.wdf_we", wdf_we, 1'b0);
    end
    step(); le_wv = 1; pf_v = 1; le_wd = 128'h22;
    #1 gchk("wst.b1", 0, 0, 0, 0, '0, 0);
    chk("wst.b1.wrdy", le_wrdy, 1'b1);
    chk("wst.b1.wdf_din", wdf_din, 128'h22);
    step(); pf_v = 1; af_full = 1; gp_v = 1;
    #1 gchk("wst.affull", 0, 0, 0, 0, '0, 0);
    step(); pf_v = 1;
    #1 gchk("wst.pf", 1, 0, 0, 1, 31'h0000_0055, 1); sb.push_back(0);
    for (int i = 0; i < 2; i++) rbeat("wst.ret", 128'hE0 + 128'(i));

    // Orphan data: sticky error, cleared by reset
    rbeat("orph", 128'hF0);
    step(); #1 chk("orph.err", err, 1'b1);
    step(); #1 chk("orph.hold", err, 1'b1);
    do_reset();

    // Reset in WR_B1 with two reads outstanding
    for (int i = 0; i < 2; i++) begin
      step(); gp_v = 1; gp_a = 31'(32'h600 + i);
      #1 gchk("rw.gp", 0, 1, 0, 1, 31'(32'h600 + i), 1); sb.push_back(1);
    end
    step(); le_v = 1; le_a = 31'h0000_0777;
    #1 gchk("rw.le", 0, 0, 1, 1, 31'h0000_0777, 0);
    do_reset();
    step(); le_wv = 1;
    #1 chk("rw.idle.wrdy", le_wrdy, 1'b0);
    rbeat("rw.orph", 128'h99);
    step(); #1 chk("rw.err", err, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TAG_DEPTH, default 4, SHALL set the number of outstanding read requests tracked (power of 2, 2..16).
REQ-002 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-004 pf_req_valid / pf_req_addr  in  1/31  SHALL be the pixel-feeder read request and its DRAM address.
REQ-005 pf_req_ready  out  1  SHALL indicate the pixel-feeder request is accepted this cycle.
REQ-006 gp_req_valid / gp_req_addr  in  1/31  SHALL be the GP instruction-fetch read request and its address.
REQ-007 gp_req_ready  out  1  SHALL indicate the GP request is accepted this cycle.
REQ-008 le_req_valid / le_req_addr  in  1/31  SHALL be the line-engine write request; le_wdata (in 128) and le_wmask (in 16) carry beat 0 alongside it.
REQ-009 le_req_ready  out  1  SHALL accept the write address plus beat 0.
REQ-010 le_wdata_valid  in  1 / le_wdata_ready  out  1  SHALL handshake write beat 1 on le_wdata/le_wmask.
REQ-011 af_wr_en  out  1, af_addr_din  out  31, af_rnw  out  1 (1=read), af_full  in  1  SHALL form the DRAM address-FIFO port.
REQ-012 wdf_wr_en  out  1, wdf_din  out  128, wdf_mask_din  out  16, wdf_full  in  1  SHALL form the DRAM write-data-FIFO port.
REQ-013 rdf_valid  in  1, rdf_dout  in  128, rdf_rd_en  out  1  SHALL form the DRAM read-data-FIFO port.
REQ-014 rd_data  out  128, pf_rd_valid  out  1, gp_rd_valid  out  1  SHALL return read beats to the owning requester.
REQ-015 err_orphan  out  1  SHALL flag read data arriving with no outstanding tag.

Function
REQ-016 States SHALL be IDLE and WR_B1; all grants happen only in IDLE.
REQ-017 In IDLE, eligible: PF/GP read needs af_full=0 and tag count < TAG_DEPTH; LE write needs af_full=0 and wdf_full=0.
REQ-018 PF SHALL have fixed highest priority; GP and LE SHALL share round-robin via 1-bit pointer rr (0 prefers GP); rr flips to the non-granted side after each GP or LE grant, unchanged on PF grant.
REQ-019 Read grant SHALL, combinationally in the same cycle: assert af_wr_en=1, af_rnw=1, af_addr_din=granted addr, the granted *_req_ready=1, and push tag (0=PF, 1=GP).
REQ-020 Write grant SHALL, same cycle: af_wr_en=1, af_rnw=0, af_addr_din=le_req_addr, wdf_wr_en=1, wdf_din=le_wdata, wdf_mask_din=le_wmask, le_req_ready=1; next state WR_B1.
REQ-021 In WR_B1: le_wdata_ready = le_wdata_valid & !wdf_full; on that handshake wdf_wr_en=1 with beat 1 and next state IDLE; no af_wr_en and no read grants in WR_B1.
REQ-022 At most one af_wr_en per cycle; *_req_ready SHALL be 0 for non-granted requesters.
REQ-023 rdf_rd_en SHALL be constant 1.
REQ-024 Each read SHALL return exactly 2 beats; 1-bit beat counter toggles on each rdf_valid; tag popped on the second beat.
REQ-025 On rdf_valid with tag non-empty: rd_data=rdf_dout, and pf_rd_valid or gp_rd_valid=1 per head tag, same cycle (combinational).
REQ-026 On rdf_valid with tag empty: no *_rd_valid, err_orphan set sticky until reset, counter unchanged.
REQ-027 Read grant eligibility SHALL use the tag count before any same-cycle pop (full blocks issue even if popping).
REQ-028 Simultaneous push and pop SHALL leave count unchanged; tag FIFO wraps modulo TAG_DEPTH.
REQ-029 Address and data SHALL pass unmodified; no width conversion.

Reset
REQ-030 rst_n=0 at any clock SHALL force: state IDLE, rr=0, tag FIFO empty (count 0), beat counter 0, err_orphan 0; mid-write WR_B1 abandoned.
REQ-031 During reset, af_wr_en, wdf_wr_en, all *_req_ready, le_wdata_ready, pf_rd_valid, gp_rd_valid SHALL be 0; rdf_rd_en SHALL be 1.

Verification
REQ-032 PF and GP both valid, af_full=0, count 0 -> PF granted, af_addr_din=pf_req_addr, af_rnw=1; GP granted next cycle.
REQ-033 GP and LE continuously valid, PF idle -> grants alternate GP, LE(+WR_B1 beat), GP, LE; no two consecutive GP grants.
REQ-034 TAG_DEPTH=4, four GP reads issued, no returns -> fifth read blocked (gp_req_ready=0); after 2 rdf_valid beats -> gp_rd_valid twice, then fifth read accepted.
REQ-035 Write grant, wdf_full=1 in WR_B1 for 3 cycles -> le_wdata_ready=0, no reads granted; wdf_full=0 -> beat 1 written, IDLE next.
REQ-036 rdf_valid with empty tag FIFO -> err_orphan=1, held; rst_n=0 one cycle -> err_orphan=0.
REQ-037 rst_n=0 in WR_B1 with two tags outstanding -> IDLE, count 0, next rdf_valid raises err_orphan.
